// File: rtl/pkg_switch_gesture.sv
// Shared types and helpers for the switch gesture classifier.
//   state_e   : per-channel gesture FSM states
//   cnt_width : tick-counter width wide enough for the largest timing limit
package pkg_switch_gesture;

  typedef enum logic [2:0] {
    IDLE,
    DOWN1,
    WAIT2,
    DOWN2,
    LONG
  } state_e;

  // One spare bit above the largest limit so a counter never aliases a limit value.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/drv_switch_gesture_ch.sv
// One channel of the gesture classifier: FSM, tick counter and registered event pulses.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_tick           : shared timing tick from the prescaler
//   i_click/i_release: one-cycle debounced press/release pulses
//   o_short/o_double/o_long/o_repeat : one-cycle registered event pulses
//   o_event_next     : unregistered "an event fires at the next edge", for the top-level OR
module drv_switch_gesture_ch
  import pkg_switch_gesture::*;
#(
  parameter int unsigned p_LONG_T   = 800,
  parameter int unsigned p_DOUBLE_T = 250,
  parameter int unsigned p_REPEAT_T = 100,
  parameter int unsigned p_CNT_W    = 11
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_click,
  input  logic i_release,
  output logic o_short,
  output logic o_double,
  output logic o_long,
  output logic o_repeat,
  output logic o_event_next
);

  localparam logic [p_CNT_W-1:0] c_LONG_M1 = p_CNT_W'(p_LONG_T - 1);
  localparam logic [p_CNT_W-1:0] c_DBL_M1  = p_CNT_W'(p_DOUBLE_T - 1);
  localparam logic [p_CNT_W-1:0] c_REP_M1  = p_CNT_W'((p_REPEAT_T > 0) ? p_REPEAT_T - 1 : 0);
  localparam logic               c_REP_EN  = (p_REPEAT_T != 0);

  state_e             r_state;
  logic [p_CNT_W-1:0] r_cnt;
  logic               r_short, r_double, r_long, r_repeat;

  // Click and release together is a protocol violation: both are dropped.
  logic w_clk, w_rel, w_long_hit, w_dbl_hit, w_rep_hit;
  assign w_clk      = i_click & ~i_release;
  assign w_rel      = i_release & ~i_click;
  assign w_long_hit = i_tick && (r_cnt == c_LONG_M1);
  assign w_dbl_hit  = i_tick && (r_cnt == c_DBL_M1);
  assign w_rep_hit  = c_REP_EN && i_tick && (r_cnt == c_REP_M1);

  assign o_event_next = ((r_state == DOWN1) && !w_rel && w_long_hit) ||
                        ((r_state == WAIT2) && !w_clk && w_dbl_hit)  ||
                        ((r_state == DOWN2) && (w_rel || w_long_hit)) ||
                        ((r_state == LONG)  && !w_rel && w_rep_hit);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // Counter parked at zero so it cannot wrap while idle.
          r_cnt <= '0;
          if (w_clk) r_state <= DOWN1;
        end
        DOWN1: begin
          if (w_rel) begin
            r_state <= WAIT2;
            r_cnt   <= '0;
          end else if (w_long_hit) begin
            r_long  <= 1'b1;
            r_state <= LONG;
            r_cnt   <= '0;
          end else if (i_tick) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT2: begin
          if (w_clk) begin
            r_state <= DOWN2;
            r_cnt   <= '0;
          end else if (w_dbl_hit) begin
            r_short <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (i_tick) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DOWN2: begin
          if (w_rel) begin
            r_double <= 1'b1;
            r_state  <= IDLE;
            r_cnt    <= '0;
          end else if (w_long_hit) begin
            // Second press held long still reports as a double click, not a long press.
            r_double <= 1'b1;
            r_state  <= LONG;
            r_cnt    <= '0;
          end else if (i_tick) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LONG: begin
          if (w_rel) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_rep_hit) begin
            r_repeat <= 1'b1;
            r_cnt    <= '0;
          end else if (i_tick && c_REP_EN) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_short  = r_short;
  assign o_double = r_double;
  assign o_long   = r_long;
  assign o_repeat = r_repeat;

endmodule

// File: rtl/drv_switch_gesture.sv
// Gesture classifier for a row of debounced switches.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_click      : per-channel press-edge pulses
//   i_release    : per-channel release-edge pulses
//   o_short, o_double, o_long, o_repeat : per-channel one-cycle event pulses
//   o_event_any  : registered OR of all event bits, aligned with them
module drv_switch_gesture
  import pkg_switch_gesture::*;
#(
  parameter int unsigned p_COUNT    = 4,
  parameter int unsigned p_TICK_DIV = 50000,
  parameter int unsigned p_LONG_T   = 800,
  parameter int unsigned p_DOUBLE_T = 250,
  parameter int unsigned p_REPEAT_T = 100
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [p_COUNT-1:0] i_click,
  input  logic [p_COUNT-1:0] i_release,
  output logic [p_COUNT-1:0] o_short,
  output logic [p_COUNT-1:0] o_double,
  output logic [p_COUNT-1:0] o_long,
  output logic [p_COUNT-1:0] o_repeat,
  output logic               o_event_any
);

  localparam int unsigned           c_CNT_W   = cnt_width(p_LONG_T, p_DOUBLE_T, p_REPEAT_T);
  localparam int unsigned           c_PRE_W   = $clog2(p_TICK_DIV);
  localparam logic [c_PRE_W-1:0]    c_PRE_MAX = c_PRE_W'(p_TICK_DIV - 1);

  logic [c_PRE_W-1:0] r_presc;
  logic               r_event_any;
  logic               w_tick;
  logic [p_COUNT-1:0] w_event_next;

  assign w_tick = (r_presc == c_PRE_MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc     <= '0;
      r_event_any <= 1'b0;
    end else begin
      r_presc     <= w_tick ? '0 : r_presc + 1'b1;
      r_event_any <= |w_event_next;
    end
  end

  for (genvar g = 0; g < p_COUNT; g++) begin : g_ch
    drv_switch_gesture_ch #(
      .p_LONG_T  (p_LONG_T),
      .p_DOUBLE_T(p_DOUBLE_T),
      .p_REPEAT_T(p_REPEAT_T),
      .p_CNT_W   (c_CNT_W)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_tick      (w_tick),
      .i_click     (i_click[g]),
      .i_release   (i_release[g]),
      .o_short     (o_short[g]),
      .o_double    (o_double[g]),
      .o_long      (o_long[g]),
      .o_repeat    (o_repeat[g]),
      .o_event_next(w_event_next[g])
    );
  end

  assign o_event_any = r_event_any;

endmodule

// File: tb/tb_drv_switch_gesture.sv
module tb_drv_switch_gesture;

  localparam int unsigned NCH = 4;
  localparam int unsigned DIV = 4;
  localparam int unsigned LT  = 10;
  localparam int unsigned DT  = 5;
  localparam int unsigned RT  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] t_click, t_rel;
  logic [NCH-1:0] o_short, o_double, o_long, o_repeat;
  logic           o_event_any;

  always #5 clk = ~clk;

  drv_switch_gesture #(
    .p_COUNT   (NCH),
    .p_TICK_DIV(DIV),
    .p_LONG_T  (LT),
    .p_DOUBLE_T(DT),
    .p_REPEAT_T(RT)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_click    (t_click),
    .i_release  (t_rel),
    .o_short    (o_short),
    .o_double   (o_double),
    .o_long     (o_long),
    .o_repeat   (o_repeat),
    .o_event_any(o_event_any)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: each channel is a gesture phase plus ticks elapsed in that phase.
  // Phase: 0 idle, 1 first press held, 2 gap after release, 3 second press held, 4 long held.
  int             m_phase[NCH];
  int             m_ticks[NCH];
  int             m_cyc = 0;
  bit             m_en  = 0;
  logic [NCH-1:0] e_short = '0, e_double = '0, e_long = '0, e_repeat = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_en  = 1;
      m_cyc = 0;
      for (int c = 0; c < NCH; c++) begin
        m_phase[c] = 0;
        m_ticks[c] = 0;
      end
      e_short = '0; e_double = '0; e_long = '0; e_repeat = '0;
    end else begin
      bit tick;
      tick = (m_cyc % DIV) == DIV - 1;
      m_cyc++;
      e_short = '0; e_double = '0; e_long = '0; e_repeat = '0;
      for (int c = 0; c < NCH; c++) begin
        bit press, lift;
        int after;
        press = t_click[c] && !t_rel[c];
        lift  = t_rel[c] && !t_click[c];
        after = m_ticks[c] + (tick ? 1 : 0);
        case (m_phase[c])
          0: if (press) begin m_phase[c] = 1; m_ticks[c] = 0; end
          1: if (lift) begin m_phase[c] = 2; m_ticks[c] = 0; end
             else if (tick && after == LT) begin e_long[c] = 1; m_phase[c] = 4; m_ticks[c] = 0; end
             else m_ticks[c] = after;
          2: if (press) begin m_phase[c] = 3; m_ticks[c] = 0; end
             else if (tick && after == DT) begin e_short[c] = 1; m_phase[c] = 0; m_ticks[c] = 0; end
             else m_ticks[c] = after;
          3: if (lift) begin e_double[c] = 1; m_phase[c] = 0; m_ticks[c] = 0; end
             else if (tick && after == LT) begin e_double[c] = 1; m_phase[c] = 4; m_ticks[c] = 0; end
             else m_ticks[c] = after;
          default: if (lift) begin m_phase[c] = 0; m_ticks[c] = 0; end
             else if (RT > 0 && tick && after == RT) begin e_repeat[c] = 1; m_ticks[c] = 0; end
             else m_ticks[c] = after;
        endcase
      end
    end
  end

  // Running per-channel event tallies for the directed scenario checks.
  int n_sh[NCH], n_db[NCH], n_lg[NCH], n_rp[NCH];
  int n_any = 0;

  always @(negedge clk) begin
    if (m_en) begin
      check_eq("short",  32'(o_short),     32'(e_short));
      check_eq("double", 32'(o_double),    32'(e_double));
      check_eq("long",   32'(o_long),      32'(e_long));
      check_eq("repeat", 32'(o_repeat),    32'(e_repeat));
      check_eq("any",    32'(o_event_any), 32'(|{e_short, e_double, e_long, e_repeat}));
      for (int c = 0; c < NCH; c++) begin
        if (o_short[c] === 1'b1)  n_sh[c]++;
        if (o_double[c] === 1'b1) n_db[c]++;
        if (o_long[c] === 1'b1)   n_lg[c]++;
        if (o_repeat[c] === 1'b1) n_rp[c]++;
      end
      if (o_event_any === 1'b1) n_any++;
    end
  end

  // Inputs are applied just after a falling edge and sampled at the next rising edge.
  task automatic step(input logic [NCH-1:0] c, input logic [NCH-1:0] r);
    t_click = c;
    t_rel   = r;
    @(negedge clk);
    t_click = '0;
    t_rel   = '0;
  endtask

  task automatic idle(input int n);
    t_click = '0;
    t_rel   = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int b_sh0, b_sh3, b_db1, b_sh1, b_lg1, b_lg2, b_rp2, b_sh2, b_any, b_tot;
    int k0, e_edge, nt;
    for (int c = 0; c < NCH; c++) begin
      n_sh[c] = 0; n_db[c] = 0; n_lg[c] = 0; n_rp[c] = 0;
    end
    rst = 1'b1; t_click = '0; t_rel = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", 32'({o_short, o_double, o_long, o_repeat, o_event_any}), 32'd0);
    rst = 1'b0;

    // 1: single short click on ch0
    b_sh0 = n_sh[0];
    step(4'b0001, 4'b0000); idle(7); step(4'b0000, 4'b0001); idle(40);
    check_eq("t1_short0", 32'(n_sh[0] - b_sh0), 32'd1);

    // 2: double click on ch1
    b_db1 = n_db[1]; b_sh1 = n_sh[1]; b_lg1 = n_lg[1];
    step(4'b0010, 0); idle(7); step(0, 4'b0010); idle(7);
    step(4'b0010, 0); idle(7); step(0, 4'b0010); idle(30);
    check_eq("t2_double1", 32'(n_db[1] - b_db1), 32'd1);
    check_eq("t2_noshort1", 32'(n_sh[1] - b_sh1), 32'd0);
    check_eq("t2_nolong1", 32'(n_lg[1] - b_lg1), 32'd0);

    // 3: long press with auto-repeat on ch2
    b_lg2 = n_lg[2]; b_rp2 = n_rp[2];
    step(4'b0100, 0); idle(99); step(0, 4'b0100); idle(20);
    check_eq("t3_long2", 32'(n_lg[2] - b_lg2), 32'd1);
    check_eq("t3_rep_ge4", 32'((n_rp[2] - b_rp2) >= 4), 32'd1);

    // 4: simultaneous short clicks on ch0 and ch3 give one merged event_any pulse
    b_sh0 = n_sh[0]; b_sh3 = n_sh[3]; b_any = n_any;
    step(4'b1001, 0); idle(7); step(0, 4'b1001); idle(40);
    check_eq("t4_short0", 32'(n_sh[0] - b_sh0), 32'd1);
    check_eq("t4_short3", 32'(n_sh[3] - b_sh3), 32'd1);
    check_eq("t4_any", 32'(n_any - b_any), 32'd1);

    // 5: reset while ch1 is long-held discards the gesture
    step(4'b0010, 0); idle(50);
    rst = 1'b1; idle(2); rst = 1'b0;
    b_any = n_any;
    step(0, 4'b0010); idle(40);
    check_eq("t5_silent", 32'(n_any - b_any), 32'd0);
    b_sh1 = n_sh[1];
    step(4'b0010, 0); idle(3); step(0, 4'b0010); idle(40);
    check_eq("t5_short1", 32'(n_sh[1] - b_sh1), 32'd1);

    // 6a: click and release together from idle are ignored
    b_any = n_any;
    step(4'b0100, 4'b0100); idle(60);
    check_eq("t6_both_ignored", 32'(n_any - b_any), 32'd0);

    // 6b: release lands on the edge where the long limit would be reached
    b_lg2 = n_lg[2]; b_sh2 = n_sh[2];
    k0 = m_cyc; nt = 0; e_edge = k0;
    while (nt < LT) begin
      e_edge++;
      if ((e_edge % DIV) == DIV - 1) nt++;
    end
    step(4'b0100, 0); idle(e_edge - k0 - 1); step(0, 4'b0100); idle(40);
    check_eq("t6_nolong2", 32'(n_lg[2] - b_lg2), 32'd0);
    check_eq("t6_short2", 32'(n_sh[2] - b_sh2), 32'd1);

    // Random traffic, including illegal simultaneous pulses, against the model.
    b_tot = n_checks;
    for (int i = 0; i < 3000; i++) begin
      logic [NCH-1:0] c, r;
      for (int k = 0; k < NCH; k++) begin
        c[k] = ($urandom_range(0, 19) == 0);
        r[k] = ($urandom_range(0, 19) == 0);
      end
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
      step(c, r);
      rst = 1'b0;
    end
    idle(60);
    check_eq("rand_ran", 32'(n_checks > b_tot), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
